alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Control sequencer for a single-bus CPU datapath: fetch (T0-T2) then execute (T3-T6)
// with registered Moore strobes decoded from the state being entered.
module alu_sequencer (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic [4:0] opcode,
    input  logic       mem_ready,
    output logic       PCout,
    output logic       MARin,
    output logic       PCin,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Rbout,
    output logic       Rcout,
    output logic       Yin,
    output logic       Zin,
    output logic       Zlowout,
    output logic       Zhighout,
    output logic       RZin,
    output logic       HIin,
    output logic       LOin,
    output logic       ADD,
    output logic       SUB,
    output logic       MUL,
    output logic       DIV,
    output logic       AND,
    output logic       OR,
    output logic       SHR,
    output logic       SHRA,
    output logic       SHL,
    output logic       ROR,
    output logic       ROL,
    output logic       NEG,
    output logic       NOT,
    output logic       IncPC,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_FIN  = 4'd8;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int C_PCOUT = 0;
    localparam int C_MARIN = 1;
    localparam int C_PCIN = 2;
    localparam int C_MDRIN = 3;
    localparam int C_MDROUT = 4;
    localparam int C_IRIN = 5;
    localparam int C_RBOUT = 6;
    localparam int C_RCOUT = 7;
    localparam int C_YIN = 8;
    localparam int C_ZIN = 9;
    localparam int C_ZLOW = 10;
    localparam int C_ZHIGH = 11;
    localparam int C_RZIN = 12;
    localparam int C_HIIN = 13;
    localparam int C_LOIN = 14;
    localparam int C_ADD = 15;
    localparam int C_SUB = 16;
    localparam int C_MUL = 17;
    localparam int C_DIV = 18;
    localparam int C_AND = 19;
    localparam int C_OR = 20;
    localparam int C_SHR = 21;
    localparam int C_SHRA = 22;
    localparam int C_SHL = 23;
    localparam int C_ROR = 24;
    localparam int C_ROL = 25;
    localparam int C_NEG = 26;
    localparam int C_NOT = 27;
    localparam int C_INCPC = 28;
    localparam int C_BUSY = 29;
    localparam int C_DONE = 30;

    logic [3:0]  state;
    logic [3:0]  state_d;
    logic [4:0]  op_q;
    logic [4:0]  op_d;
    logic        illegal_d;
    logic        illegal_q;
    logic [30:0] ctl_q;

    function automatic logic is_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        is_unary = (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_wide(input logic [4:0] op);
        is_wide = (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic [30:0] alu_select(input logic [4:0] op);
        alu_select = '0;
        case (op)
            OP_ADD:  alu_select[C_ADD]  = 1'b1;
            OP_SUB:  alu_select[C_SUB]  = 1'b1;
            OP_SHR:  alu_select[C_SHR]  = 1'b1;
            OP_SHRA: alu_select[C_SHRA] = 1'b1;
            OP_SHL:  alu_select[C_SHL]  = 1'b1;
            OP_ROR:  alu_select[C_ROR]  = 1'b1;
            OP_ROL:  alu_select[C_ROL]  = 1'b1;
            OP_AND:  alu_select[C_AND]  = 1'b1;
            OP_OR:   alu_select[C_OR]   = 1'b1;
            OP_MUL:  alu_select[C_MUL]  = 1'b1;
            OP_DIV:  alu_select[C_DIV]  = 1'b1;
            OP_NEG:  alu_select[C_NEG]  = 1'b1;
            OP_NOT:  alu_select[C_NOT]  = 1'b1;
            default: alu_select = '0;
        endcase
    endfunction

    // Strobe pattern for a given state; registered against the next state so
    // the outputs line up with the state they belong to.
    function automatic logic [30:0] decode(input logic [3:0] st, input logic [4:0] op);
        decode = '0;
        case (st)
            S_T0: begin
                decode[C_PCOUT] = 1'b1;
                decode[C_MARIN] = 1'b1;
                decode[C_INCPC] = 1'b1;
                decode[C_ZIN]   = 1'b1;
            end
            S_T1: begin
                decode[C_ZLOW]  = 1'b1;
                decode[C_PCIN]  = 1'b1;
                decode[C_MDRIN] = 1'b1;
            end
            S_T2: begin
                decode[C_MDROUT] = 1'b1;
                decode[C_IRIN]   = 1'b1;
            end
            S_T3: begin
                decode[C_RBOUT] = !is_unary(op);
                decode[C_YIN]   = !is_unary(op);
            end
            S_T4: begin
                decode = alu_select(op);
                decode[C_RBOUT] = is_unary(op);
                decode[C_RCOUT] = !is_unary(op);
                decode[C_ZIN]   = 1'b1;
            end
            S_T5: begin
                decode[C_ZLOW] = 1'b1;
                decode[C_LOIN] = is_wide(op);
                decode[C_RZIN] = !is_wide(op);
            end
            S_T6: begin
                decode[C_ZHIGH] = 1'b1;
                decode[C_HIIN]  = 1'b1;
            end
            S_FIN: decode[C_DONE] = 1'b1;
            default: decode = '0;
        endcase
        decode[C_BUSY] = (st != S_IDLE);
    endfunction

    always_comb begin
        state_d   = state;
        op_d      = op_q;
        illegal_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    op_d = opcode;
                    if (is_legal(opcode)) state_d = S_T0;
                    else                  illegal_d = 1'b1;
                end
            end
            S_T0:  state_d = S_T1;
            S_T1:  state_d = mem_ready ? S_T2 : S_T1;
            S_T2:  state_d = S_T3;
            S_T3:  state_d = S_T4;
            S_T4:  state_d = S_T5;
            S_T5:  state_d = is_wide(op_q) ? S_T6 : S_FIN;
            S_T6:  state_d = S_FIN;
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= S_IDLE;
            op_q      <= '0;
            ctl_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_d;
            op_q      <= op_d;
            ctl_q     <= decode(state_d, op_d);
            illegal_q <= illegal_d;
        end
    end

    assign PCout    = ctl_q[C_PCOUT];
    assign MARin    = ctl_q[C_MARIN];
    assign PCin     = ctl_q[C_PCIN];
    assign MDRin    = ctl_q[C_MDRIN];
    assign MDRout   = ctl_q[C_MDROUT];
    assign IRin     = ctl_q[C_IRIN];
    assign Rbout    = ctl_q[C_RBOUT];
    assign Rcout    = ctl_q[C_RCOUT];
    assign Yin      = ctl_q[C_YIN];
    assign Zin      = ctl_q[C_ZIN];
    assign Zlowout  = ctl_q[C_ZLOW];
    assign Zhighout = ctl_q[C_ZHIGH];
    assign RZin     = ctl_q[C_RZIN];
    assign HIin     = ctl_q[C_HIIN];
    assign LOin     = ctl_q[C_LOIN];
    assign ADD      = ctl_q[C_ADD];
    assign SUB      = ctl_q[C_SUB];
    assign MUL      = ctl_q[C_MUL];
    assign DIV      = ctl_q[C_DIV];
    assign AND      = ctl_q[C_AND];
    assign OR       = ctl_q[C_OR];
    assign SHR      = ctl_q[C_SHR];
    assign SHRA     = ctl_q[C_SHRA];
    assign SHL      = ctl_q[C_SHL];
    assign ROR      = ctl_q[C_ROR];
    assign ROL      = ctl_q[C_ROL];
    assign NEG      = ctl_q[C_NEG];
    assign NOT      = ctl_q[C_NOT];
    assign IncPC    = ctl_q[C_INCPC];
    assign busy     = ctl_q[C_BUSY];
    assign done     = ctl_q[C_DONE];
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized instruction streams for alu_sequencer, checked cycle by cycle
// against an expected strobe trace built from the instruction's phase list.
module tb_alu_sequencer;

    logic       clock = 1'b0;
    logic       clear;
    logic       start;
    logic [4:0] opcode;
    logic       mem_ready;
    logic PCout, MARin, PCin, MDRin, MDRout, IRin, Rbout, Rcout, Yin, Zin;
    logic Zlowout, Zhighout, RZin, HIin, LOin;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC;
    logic busy, done, illegal;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Rbout(Rbout), .Rcout(Rcout), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .RZin(RZin), .HIin(HIin), .LOin(LOin),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR), .SHR(SHR),
        .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .IncPC(IncPC), .busy(busy), .done(done), .illegal(illegal)
    );

    // Bench-side bit positions of the observed output word.
    localparam int B_PCOUT = 0, B_MARIN = 1, B_PCIN = 2, B_MDRIN = 3, B_MDROUT = 4;
    localparam int B_IRIN = 5, B_RBOUT = 6, B_RCOUT = 7, B_YIN = 8, B_ZIN = 9;
    localparam int B_ZLOW = 10, B_ZHIGH = 11, B_RZIN = 12, B_HIIN = 13, B_LOIN = 14;
    localparam int B_INCPC = 28, B_BUSY = 29, B_DONE = 30, B_ILL = 31;

    logic [31:0] obs;
    assign obs = {illegal, done, busy, IncPC, NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND,
                  DIV, MUL, SUB, ADD, LOin, HIin, RZin, Zhighout, Zlowout, Zin, Yin, Rcout,
                  Rbout, IRin, MDRout, MDRin, PCin, MARin, PCout};

    typedef enum int {P_IDLE, P_T0, P_T1, P_T2, P_T3, P_T4, P_T5, P_T6, P_FIN} phase_t;

    logic [4:0] legal_ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                   5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                   5'b10000, 5'b10001, 5'b10010};
    // Select bit for each legal opcode, same order as legal_ops.
    int sel_pos [13] = '{15, 16, 21, 22, 23, 24, 25, 19, 20, 17, 18, 26, 27};

    function automatic int op_index(input logic [4:0] op);
        op_index = -1;
        for (int i = 0; i < 13; i++)
            if (legal_ops[i] == op) op_index = i;
    endfunction

    function automatic logic [31:0] expect_out(input phase_t ph, input logic [4:0] op);
        logic [31:0] e;
        logic unary, wide;
        e = '0;
        unary = (op == 5'b10001) || (op == 5'b10010);
        wide  = (op == 5'b01111) || (op == 5'b10000);
        case (ph)
            P_T0:  begin e[B_PCOUT] = 1; e[B_MARIN] = 1; e[B_INCPC] = 1; e[B_ZIN] = 1; end
            P_T1:  begin e[B_ZLOW] = 1; e[B_PCIN] = 1; e[B_MDRIN] = 1; end
            P_T2:  begin e[B_MDROUT] = 1; e[B_IRIN] = 1; end
            P_T3:  if (!unary) begin e[B_RBOUT] = 1; e[B_YIN] = 1; end
            P_T4:  begin
                if (unary) e[B_RBOUT] = 1; else e[B_RCOUT] = 1;
                e[B_ZIN] = 1;
                e[sel_pos[op_index(op)]] = 1;
            end
            P_T5:  begin e[B_ZLOW] = 1; if (wide) e[B_LOIN] = 1; else e[B_RZIN] = 1; end
            P_T6:  begin e[B_ZHIGH] = 1; e[B_HIIN] = 1; end
            P_FIN: e[B_DONE] = 1;
            default: e = '0;
        endcase
        if (ph != P_IDLE) e[B_BUSY] = 1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the FIN negedge.
    // stop_at >= 0 aborts via clear while in that phase.
    task automatic run_instr(input logic [4:0] op, input int stalls, input bit hold,
                             input int stop_at);
        phase_t q[$];
        int t1_seen = 0;
        int done_at = -1;
        int want_lat;
        bit wide;
        wide = (op == 5'b01111) || (op == 5'b10000);
        q.push_back(P_T0);
        repeat (stalls + 1) q.push_back(P_T1);
        q.push_back(P_T2); q.push_back(P_T3); q.push_back(P_T4); q.push_back(P_T5);
        if (wide) q.push_back(P_T6);
        q.push_back(P_FIN);
        want_lat = 7 + (wide ? 1 : 0) + stalls;

        start = 1'b1;
        opcode = op;
        mem_ready = $urandom_range(0, 1);
        for (int c = 0; c < q.size(); c++) begin
            @(negedge clock);
            if (!hold) begin
                start = 1'b0;
                opcode = 5'($urandom);
            end
            chk($sformatf("op%b_cyc%0d", op, c + 1), obs, expect_out(q[c], op));
            if (obs[B_DONE] && done_at < 0) done_at = c + 1;
            if (q[c] == P_T1) begin
                mem_ready = (t1_seen == stalls);
                t1_seen++;
            end else begin
                mem_ready = $urandom_range(0, 1);
            end
            if (int'(q[c]) == stop_at) begin
                #2 clear = 1'b1;
                #1 chk("async_clear_outputs", obs, 32'h0);
                return;
            end
        end
        chk($sformatf("latency_op%b", op), 32'(done_at), 32'(want_lat));
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clock);
        chk(tag, obs, 32'h0);
    endtask

    task automatic run_illegal(input logic [4:0] op);
        start = 1'b1;
        opcode = op;
        @(negedge clock);
        start = 1'b0;
        chk($sformatf("illegal_pulse_%b", op), obs, 32'h8000_0000);
        idle_cycle("illegal_cleared");
    endtask

    initial begin
        logic [4:0] op;
        bit hold;
        clear = 1'b1;
        start = 1'b0;
        opcode = '0;
        mem_ready = 1'b0;
        #1 chk("reset_outputs", obs, 32'h0);
        @(negedge clock);
        @(negedge clock);
        chk("reset_held", obs, 32'h0);
        clear = 1'b0;
        idle_cycle("idle_after_reset");

        // ADD, no stall
        run_instr(5'b00011, 0, 1'b0, -1);
        idle_cycle("add_back_idle");
        // MUL
        run_instr(5'b01111, 0, 1'b0, -1);
        idle_cycle("mul_back_idle");
        // AND with 3 stall cycles in T1
        run_instr(5'b01010, 3, 1'b0, -1);
        idle_cycle("and_back_idle");
        // Illegal opcode
        run_illegal(5'b11111);
        run_illegal(5'b00000);

        // DIV aborted by clear in T5
        run_instr(5'b10000, 0, 1'b0, int'(P_T5));
        @(negedge clock);
        chk("clear_hold_no_done", obs, 32'h0);
        clear = 1'b0;
        start = 1'b0;
        idle_cycle("post_abort_idle1");
        idle_cycle("post_abort_idle2");
        run_instr(5'b00011, 0, 1'b0, -1);
        idle_cycle("post_abort_add_idle");

        // NEG back-to-back with start held
        run_instr(5'b10001, 0, 1'b1, -1);
        idle_cycle("neg_gap_idle");
        run_instr(5'b10001, 1, 1'b0, -1);
        idle_cycle("neg2_idle");

        // Randomized stream of legal and illegal requests
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do op = 5'($urandom); while (op_index(op) >= 0);
                start = 1'b0;
                run_illegal(op);
            end else begin
                op = legal_ops[$urandom_range(0, 12)];
                hold = $urandom_range(0, 1);
                run_instr(op, $urandom_range(0, 3), hold, -1);
                idle_cycle($sformatf("rand_idle_%0d", n));
                start = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
